// File: rtl/fwd_pkg.sv
// Shared types and select codes for the forwarding / load-use hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fwd_pkg;

  // Operand-mux select codes; must stay in step with the EX-stage operand mux.
  localparam logic [1:0] FWD_REG = 2'b00;  // register-file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB result
  localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM result

  // Register-address width used by the shadow entries (32 architectural regs).
  localparam int RD_W = 5;

  // One shadow pipeline entry: what a stage will eventually write back.
  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            regwrite;
  } stage_t;

  // True when this stage will write a non-zero register equal to src.
  function automatic logic stage_hits(input stage_t s, input logic [RD_W-1:0] src);
    return s.valid && s.regwrite && (s.rd != '0) && (s.rd == src);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Priority compare of one EX source register against the EX/MEM and MEM/WB entries.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs every cycle.
module fwd_sel
  import fwd_pkg::*;
(
  input  logic [RD_W-1:0] rs,
  input  stage_t          exmem,
  input  stage_t          memwb,
  output logic [1:0]      sel
);

  // Younger producer (EX/MEM) wins over MEM/WB; x0 never matches.
  always_comb begin
    sel = FWD_REG;
    if (stage_hits(exmem, rs)) begin
      sel = FWD_MEM;
    end else if (stage_hits(memwb, rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding and load-use hazard controller: shadow ID/EX, EX/MEM, MEM/WB dest info.
// Latency: selects and stall are combinational in the consumer's EX / ID cycle.
// Backpressure: raises stall for one cycle on a load-use hazard; counts stall cycles.
module fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5,   // must equal fwd_pkg::RD_W
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // ID/EX shadow: writeback entry plus the source regs and load flag it needs.
  stage_t            idex;
  logic [REG_AW-1:0] idex_rs1;
  logic [REG_AW-1:0] idex_rs2;
  logic              idex_memread;

  stage_t            exmem;
  stage_t            memwb;

  // ID/EX capture: a flush or a load-use stall both insert a fully cleared bubble,
  // so a squashed instruction can neither forward nor be forwarded into.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex         <= '0;
      idex_rs1     <= '0;
      idex_rs2     <= '0;
      idex_memread <= 1'b0;
    end else if (flush_i || stall_o) begin
      idex         <= '0;
      idex_rs1     <= '0;
      idex_rs2     <= '0;
      idex_memread <= 1'b0;
    end else begin
      idex.valid    <= id_valid_i;
      idex.rd       <= id_rd_i;
      idex.regwrite <= id_regwrite_i;
      idex_rs1      <= id_rs1_i;
      idex_rs2      <= id_rs2_i;
      idex_memread  <= id_memread_i;
    end
  end

  // Later stages advance unconditionally; a stall only bubbles ID/EX.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exmem <= '0;
      memwb <= '0;
    end else begin
      exmem <= idex;
      memwb <= exmem;
    end
  end

  // Load in EX whose result an ID instruction needs next cycle: hold ID for one cycle.
  // flush_i deliberately does not mask this; the flush bubble wins in ID/EX anyway.
  always_comb begin
    stall_o = 1'b0;
    if (idex.valid && idex_memread && (idex.rd != '0) && id_valid_i) begin
      if ((id_rs1_i == idex.rd) || (id_use_rs2_i && (id_rs2_i == idex.rd))) begin
        stall_o = 1'b1;
      end
    end
  end

  // Stall-cycle performance counter, free-running wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  fwd_sel u_sel_a (
    .rs    (idex_rs1),
    .exmem (exmem),
    .memwb (memwb),
    .sel   (fwd_a_o)
  );

  fwd_sel u_sel_b (
    .rs    (idex_rs2),
    .exmem (exmem),
    .memwb (memwb),
    .sel   (fwd_b_o)
  );

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: directed vector table, reset sequence, random run.
// Latency: n/a.
// Backpressure: n/a.
module tb_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_use_rs2_i;
  logic [4:0]  id_rd_i;
  logic        id_regwrite_i;
  logic        id_memread_i;
  logic        flush_i;
  logic [1:0]  fwd_a_o;
  logic [1:0]  fwd_b_o;
  logic        stall_o;
  logic [15:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_use_rs2_i  (id_use_rs2_i),
    .id_rd_i       (id_rd_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .flush_i       (flush_i),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .stall_o       (stall_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  // Directed vector: one cycle of ID inputs and the outputs expected in that cycle.
  typedef struct {
    int v, rs1, rs2, u2, rd, rw, mr, fl;
    int ea, eb, es, ec;
  } vec_t;
  vec_t tbl[$];

  // Reference model: the instruction occupying each stage, as plain records.
  typedef struct {
    int v, rs1, rs2, rd, rw, mr;
  } ins_t;
  ins_t m_idex, m_exmem, m_memwb;
  int   m_cnt;

  function automatic int writes(input ins_t s, input int r);
    return (s.v != 0 && s.rw != 0 && s.rd != 0 && s.rd == r) ? 1 : 0;
  endfunction

  function automatic int m_sel(input int r);
    if (writes(m_exmem, r) != 0) return 2;
    if (writes(m_memwb, r) != 0) return 1;
    return 0;
  endfunction

  function automatic int m_stall();
    if (m_idex.v == 0 || m_idex.mr == 0 || m_idex.rd == 0 || id_valid_i == 1'b0) return 0;
    if (int'(id_rs1_i) == m_idex.rd) return 1;
    if (id_use_rs2_i && int'(id_rs2_i) == m_idex.rd) return 1;
    return 0;
  endfunction

  task automatic m_clear();
    m_idex  = '{default: 0};
    m_exmem = '{default: 0};
    m_memwb = '{default: 0};
    m_cnt   = 0;
  endtask

  // Move every instruction one stage on, as the clock edge does.
  task automatic m_advance();
    int s;
    s = m_stall();
    m_memwb = m_exmem;
    m_exmem = m_idex;
    if (flush_i || s != 0) begin
      m_idex = '{default: 0};
    end else begin
      m_idex.v   = int'(id_valid_i);
      m_idex.rs1 = int'(id_rs1_i);
      m_idex.rs2 = int'(id_rs2_i);
      m_idex.rd  = int'(id_rd_i);
      m_idex.rw  = int'(id_regwrite_i);
      m_idex.mr  = int'(id_memread_i);
    end
    if (s != 0) m_cnt = (m_cnt + 1) % 65536;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic row(input int v, rs1, rs2, u2, rd, rw, mr, fl, ea, eb, es, ec);
    vec_t r;
    r = '{v:v, rs1:rs1, rs2:rs2, u2:u2, rd:rd, rw:rw, mr:mr, fl:fl,
          ea:ea, eb:eb, es:es, ec:ec};
    tbl.push_back(r);
  endtask

  task automatic nop(input int ea, eb, ec);
    row(0, 0, 0, 0, 0, 0, 0, 0, ea, eb, 0, ec);
  endtask

  task automatic drive(input int v, rs1, rs2, u2, rd, rw, mr, fl);
    @(negedge clk);
    id_valid_i    = v[0];
    id_rs1_i      = rs1[4:0];
    id_rs2_i      = rs2[4:0];
    id_use_rs2_i  = u2[0];
    id_rd_i       = rd[4:0];
    id_regwrite_i = rw[0];
    id_memread_i  = mr[0];
    flush_i       = fl[0];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fwd_a"}, 32'(fwd_a_o), 0);
    chk({tag, "_fwd_b"}, 32'(fwd_b_o), 0);
    chk({tag, "_stall"}, 32'(stall_o), 0);
    chk({tag, "_cnt"},   32'(stall_cnt_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_use_rs2_i = 0;
    id_rd_i = 0; id_regwrite_i = 0; id_memread_i = 0; flush_i = 0;
    m_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 chk_all_zero("reset");
    rst_i = 1'b0;

    //   v rs1 rs2 u2 rd rw mr fl | a  b  st cnt
    // add x3 ; sub x5,x3,x4  -> EX/MEM forward on A
    row(1, 1, 2, 1, 3, 1, 0, 0,  0, 0, 0, 0);
    row(1, 3, 4, 1, 5, 1, 0, 0,  0, 0, 0, 0);
    nop(2, 0, 0); nop(0, 0, 0); nop(0, 0, 0);
    // add x3 ; add x3 ; nop ; or x6,x3,x3 -> MEM/WB forward on both
    row(1, 1, 2, 1, 3, 1, 0, 0,  0, 0, 0, 0);
    row(1, 1, 2, 1, 3, 1, 0, 0,  0, 0, 0, 0);
    nop(0, 0, 0);
    row(1, 3, 3, 1, 6, 1, 0, 0,  0, 0, 0, 0);
    nop(1, 1, 0); nop(0, 0, 0); nop(0, 0, 0);
    // add x3 ; add x3 ; or x6,x3,x3 -> double match, younger wins
    row(1, 1, 2, 1, 3, 1, 0, 0,  0, 0, 0, 0);
    row(1, 1, 2, 1, 3, 1, 0, 0,  0, 0, 0, 0);
    row(1, 3, 3, 1, 6, 1, 0, 0,  0, 0, 0, 0);
    nop(2, 2, 0); nop(0, 0, 0); nop(0, 0, 0);
    // lw x7 ; add x8,x7,x1 -> one stall, then MEM/WB forward
    row(1, 1, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0);
    row(1, 7, 1, 1, 8, 1, 0, 0,  0, 0, 1, 0);
    row(1, 7, 1, 1, 8, 1, 0, 0,  0, 0, 0, 1);
    nop(1, 0, 1); nop(0, 0, 1); nop(0, 0, 1);
    // lw x0 ; add x8,x0,x0 -> no stall, no forward
    row(1, 1, 0, 0, 0, 1, 1, 0,  0, 0, 0, 1);
    row(1, 0, 0, 1, 8, 1, 0, 0,  0, 0, 0, 1);
    nop(0, 0, 1); nop(0, 0, 1); nop(0, 0, 1);
    // lw x9 ; addi x10,x1 (rs2 field 9, unused) -> no stall
    row(1, 1, 0, 0, 9, 1, 1, 0,  0, 0, 0, 1);
    row(1, 1, 9, 0,10, 1, 0, 0,  0, 0, 0, 1);
    nop(0, 2, 1); nop(0, 0, 1); nop(0, 0, 1);
    // lw x7 ; add x8,x7,x1 flushed ; or x9,x8,x8 -> stall still raised, no forward of x8
    row(1, 1, 0, 0, 7, 1, 1, 0,  0, 0, 0, 1);
    row(1, 7, 1, 1, 8, 1, 0, 1,  0, 0, 1, 1);
    row(1, 8, 8, 1, 9, 1, 0, 0,  0, 0, 0, 2);
    nop(0, 0, 2); nop(0, 0, 2); nop(0, 0, 2);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u2,
            tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].fl);
      #1;
      chk($sformatf("vec%0d_fwd_a", i), 32'(fwd_a_o), tbl[i].ea);
      chk($sformatf("vec%0d_fwd_b", i), 32'(fwd_b_o), tbl[i].eb);
      chk($sformatf("vec%0d_stall", i), 32'(stall_o), tbl[i].es);
      chk($sformatf("vec%0d_cnt", i),   32'(stall_cnt_o), tbl[i].ec);
      @(posedge clk);
      m_advance();
    end

    // Reset while a producer (add x3) sits in EX/MEM and its consumer in EX.
    drive(1, 1, 2, 1, 3, 1, 0, 0);
    @(posedge clk); m_advance();
    drive(1, 3, 5, 1, 6, 1, 0, 0);
    @(posedge clk); m_advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("prerst_fwd_a", 32'(fwd_a_o), 2);
    rst_i = 1'b1;
    m_clear();
    #1 chk_all_zero("inrst");
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1 chk_all_zero("postrst");
    @(posedge clk); m_advance();

    // Random traffic against the reference model; small register range for many hits.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 7) != 0) ? 1 : 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            ($urandom_range(0, 2) == 0) ? 1 : 0,
            ($urandom_range(0, 7) == 0) ? 1 : 0);
      #1;
      chk($sformatf("rnd%0d_fwd_a", n), 32'(fwd_a_o), m_sel(m_idex.rs1));
      chk($sformatf("rnd%0d_fwd_b", n), 32'(fwd_b_o), m_sel(m_idex.rs2));
      chk($sformatf("rnd%0d_stall", n), 32'(stall_o), m_stall());
      chk($sformatf("rnd%0d_cnt", n),   32'(stall_cnt_o), m_cnt);
      @(posedge clk);
      m_advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
